// File: rtl/tsip_rx_framer_pkg.sv
// tsip_pkg: shared TSIP byte codes, packet IDs and receive framer state type
package tsip_pkg;
    localparam logic [7:0] TSIP_DLE = 8'h10;
    localparam logic [7:0] TSIP_ETX = 8'h03;
    localparam logic [7:0] TSIP_ID_CMD = 8'h8E;
    localparam logic [7:0] TSIP_ID_RPT = 8'h8F;
    localparam logic [7:0] TSIP_SUB_TIMING = 8'hAB;
    typedef enum logic [2:0] {
        IDLE,
        HDR_DLE,
        HDR_ID,
        DATA,
        DATA_DLE,
        SKIP,
        SKIP_DLE
    } tsip_state_e;
endpackage

// File: rtl/tsip_rx_framer_if.sv
// tsip_rx_framer_if: byte strobe bus from uart_rx (master) into the framer (slave)
interface tsip_rx_framer_if;
    logic rx_dv;
    logic [7:0] rx_byte;
    modport master (output rx_dv, rx_byte);
    modport slave (input rx_dv, rx_byte);
endinterface

// File: rtl/tsip_rx_framer.sv
// tsip_rx_framer: TSIP packet framer with DLE destuffing and ID/subcode/length filtering; TSIP_RX_TIMEOUT_EN adds an inter-byte timeout
module tsip_rx_framer
    import tsip_pkg::*;
#(
    parameter logic [7:0] P_ID = TSIP_ID_RPT,
    parameter logic [7:0] P_SUBCODE = TSIP_SUB_TIMING,
    parameter int P_LEN = 17,
    parameter int P_TIMEOUT_CLKS = 20840
) (
    input logic i_clk,
    input logic i_rst,
    input logic i_en,
    tsip_rx_framer_if.slave rx,
    output logic o_pkt_dv,
    output logic [8*P_LEN-1:0] o_data,
    output logic o_err_len,
    output logic o_err_frame,
    output logic [15:0] o_pkt_cnt
);
    localparam int CW = $clog2(P_LEN + 1);
    tsip_state_e state, nxt;
    logic [CW-1:0] count;
    logic [7:0] mem [P_LEN];
    logic [8*P_LEN-1:0] payload;
    logic is_dle, is_etx, is_id, sub_hit, full, timeout;
    logic strobe, sub_ok, store_req, ev_store, eop, ev_pkt, ev_len, ev_frame;
    assign is_dle = rx.rx_byte == TSIP_DLE;
    assign is_etx = rx.rx_byte == TSIP_ETX;
    assign is_id = rx.rx_byte == P_ID;
    assign sub_hit = P_SUBCODE == 8'h00 || rx.rx_byte == P_SUBCODE;
    assign full = count == CW'(P_LEN);
`ifdef TSIP_RX_TIMEOUT_EN
    localparam int TW = $clog2(P_TIMEOUT_CLKS + 1);
    logic [TW-1:0] to_cnt;
    assign timeout = i_en && state != IDLE && !rx.rx_dv && to_cnt == TW'(P_TIMEOUT_CLKS);
    // idle-time counter, restarted by every byte and parked while idle
    always_ff @(posedge i_clk)
        to_cnt <= (i_rst || rx.rx_dv || state == IDLE) ? '0 : to_cnt + 1'b1;
`else
    assign timeout = 1'b0;
`endif
    // state register
    always_ff @(posedge i_clk)
        state <= i_rst ? IDLE : nxt;
    // next state: advance only on byte strobes; disable or timeout drops back to idle
    always_comb begin
        nxt = state;
        if (!i_en || timeout)
            nxt = IDLE;
        else if (rx.rx_dv)
            case (state)
                IDLE: nxt = is_dle ? HDR_DLE : IDLE;
                HDR_DLE: nxt = is_id ? HDR_ID : (is_dle || is_etx) ? IDLE : SKIP;
                HDR_ID: nxt = sub_hit ? DATA : SKIP;
                DATA: nxt = is_dle ? DATA_DLE : full ? SKIP : DATA;
                DATA_DLE: nxt = is_dle ? (full ? SKIP : DATA) : is_etx ? IDLE : is_id ? HDR_ID : SKIP;
                SKIP: nxt = is_dle ? SKIP_DLE : SKIP;
                SKIP_DLE: nxt = is_etx ? IDLE : SKIP;
                default: nxt = IDLE;
            endcase
    end
    // decoded events; a stuffed DLE pair stores the received 0x10 byte itself
    always_comb begin
        strobe = i_en && rx.rx_dv;
        sub_ok = strobe && state == HDR_ID && sub_hit;
        store_req = strobe && (state == DATA ? !is_dle : state == DATA_DLE && is_dle);
        ev_store = store_req && !full;
        eop = strobe && state == DATA_DLE && is_etx;
        ev_pkt = eop && full;
        ev_len = (store_req && full) || (eop && !full);
        ev_frame = (strobe && state == DATA_DLE && !is_dle && !is_etx) || timeout;
    end
    // payload storage
    always_ff @(posedge i_clk)
        if (sub_ok)
            mem[0] <= rx.rx_byte;
        else if (ev_store)
            mem[count] <= rx.rx_byte;
    for (genvar k = 0; k < P_LEN; k++) begin : g_pack
        assign payload[8*k+:8] = mem[k];
    end
    // byte count, registered event pulses and published packet
    always_ff @(posedge i_clk)
        if (i_rst) begin
            count <= '0;
            o_pkt_dv <= 1'b0;
            o_err_len <= 1'b0;
            o_err_frame <= 1'b0;
            o_data <= '0;
            o_pkt_cnt <= '0;
        end else begin
            o_pkt_dv <= ev_pkt;
            o_err_len <= ev_len;
            o_err_frame <= ev_frame;
            if (sub_ok)
                count <= CW'(1);
            else if (ev_store)
                count <= count + 1'b1;
            if (ev_pkt) begin
                o_data <= payload;
                o_pkt_cnt <= o_pkt_cnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_tsip_rx_framer.sv
// tb_tsip_rx_framer: directed-vector bench for tsip_rx_framer (timeout checks follow TSIP_RX_TIMEOUT_EN)
module tb_tsip_rx_framer;
    localparam int TO = 50;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic pkt_dv, err_len, err_frame;
    logic [135:0] data;
    logic [15:0] pkt_cnt;
    int n_cmp = 0, n_err = 0;
    int n_pkt = 0, n_len = 0, n_frm = 0, n_multi = 0;
    int p0, l0, f0;
    tsip_rx_framer_if rx_if ();
    tsip_rx_framer #(.P_TIMEOUT_CLKS(TO)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_en(en),
        .rx(rx_if.slave),
        .o_pkt_dv(pkt_dv),
        .o_data(data),
        .o_err_len(err_len),
        .o_err_frame(err_frame),
        .o_pkt_cnt(pkt_cnt)
    );
    always #5 clk = ~clk;
    // pulse tally, sampled mid-cycle
    always @(negedge clk) begin
        if (pkt_dv) n_pkt++;
        if (err_len) n_len++;
        if (err_frame) n_frm++;
        if (int'(pkt_dv) + int'(err_len) + int'(err_frame) > 1) n_multi++;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [135:0] pay(input logic [7:0] s);
        pay = '0;
        pay[7:0] = 8'hAB;
        for (int k = 1; k < 17; k++) pay[8*k+:8] = s + 8'(k - 1);
    endfunction
    task automatic send(input logic [7:0] b);
        rx_if.rx_dv = 1'b1;
        rx_if.rx_byte = b;
        @(posedge clk); #1;
        rx_if.rx_dv = 1'b0;
        @(posedge clk); #1;
    endtask
    task automatic send_chk(input logic [7:0] b, input string tag, input logic [2:0] exp);
        rx_if.rx_dv = 1'b1;
        rx_if.rx_byte = b;
        @(posedge clk); #1;
        rx_if.rx_dv = 1'b0;
        chk(tag, {pkt_dv, err_len, err_frame}, exp);
        @(posedge clk); #1;
        chk({tag, "_next"}, {pkt_dv, err_len, err_frame}, 3'b000);
    endtask
    task automatic send_data(input logic [7:0] b);
        if (b == 8'h10) send(8'h10);
        send(b);
    endtask
    task automatic send_hdr();
        send(8'h10);
        send(8'h8F);
        send(8'hAB);
    endtask
    task automatic send_payload(input logic [7:0] s);
        for (int k = 0; k < 16; k++) send_data(s + 8'(k));
    endtask
    task automatic send_end(input string tag, input logic [2:0] exp);
        send(8'h10);
        send_chk(8'h03, tag, exp);
    endtask
    task automatic snap();
        p0 = n_pkt;
        l0 = n_len;
        f0 = n_frm;
    endtask
    initial begin
        rx_if.rx_dv = 1'b0;
        rx_if.rx_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pkt_dv", pkt_dv, 0);
        chk("rst_errs", {err_len, err_frame}, 0);
        chk("rst_data", data, 0);
        chk("rst_cnt", pkt_cnt, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        // good packet with a stuffed 0x10 in the last byte
        send_hdr();
        send_payload(8'h01);
        send_end("good_eop", 3'b100);
        chk("good_data", data, pay(8'h01));
        chk("good_byte0", data[7:0], 8'hAB);
        chk("good_byte16", data[135:128], 8'h10);
        chk("good_cnt", pkt_cnt, 1);
        // foreign subcode is skipped silently
        snap();
        send(8'h10); send(8'h8F); send(8'hAC); send(8'h01); send(8'h02);
        send(8'h10); send(8'h10);
        send_end("foreign_eop", 3'b000);
        chk("foreign_pulses", (n_pkt - p0) + (n_len - l0) + (n_frm - f0), 0);
        send_hdr();
        send_payload(8'h01);
        send_end("after_foreign_eop", 3'b100);
        chk("after_foreign_cnt", pkt_cnt, 2);
        // short packet
        snap();
        send_hdr();
        for (int k = 0; k < 10; k++) send(8'h21 + 8'(k));
        send_end("short_eop", 3'b010);
        chk("short_len_once", n_len - l0, 1);
        chk("short_data", data, pay(8'h01));
        chk("short_cnt", pkt_cnt, 2);
        // framing error: DLE followed by a new ID mid-packet
        snap();
        send_hdr();
        send(8'h05);
        send(8'h10);
        send_chk(8'h8F, "frame_err", 3'b001);
        send(8'hAB);
        send_payload(8'h31);
        send_end("frame_eop", 3'b100);
        chk("frame_counts", {8'(n_frm - f0), 8'(n_pkt - p0)}, 16'h0101);
        chk("frame_data", data, pay(8'h31));
        chk("frame_cnt", pkt_cnt, 3);
        // overflow: 17th data byte has no room
        snap();
        send_hdr();
        for (int k = 0; k < 16; k++) send(8'h50 + 8'(k));
        send_chk(8'h60, "ovf_err", 3'b010);
        send(8'h61);
        send_end("ovf_eop", 3'b000);
        chk("ovf_pkts", n_pkt - p0, 0);
        chk("ovf_data", data, pay(8'h31));
        // abort by disabling after 8 payload bytes
        snap();
        send_hdr();
        for (int k = 0; k < 8; k++) send(8'h01 + 8'(k));
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        en = 1'b1;
        send_hdr();
        send_payload(8'h01);
        send_end("abort_eop", 3'b100);
        chk("abort_pulses", {8'(n_pkt - p0), 8'(n_len - l0), 8'(n_frm - f0)}, 24'h010000);
        chk("abort_data", data, pay(8'h01));
        chk("abort_cnt", pkt_cnt, 4);
        // stalled stream: timeout pulse only when the feature is built in
        send_hdr();
        send(8'h01);
        repeat (TO - 1) @(posedge clk);
        #1;
        chk("to_early", err_frame, 0);
        @(posedge clk); #1;
`ifdef TSIP_RX_TIMEOUT_EN
        chk("to_pulse", err_frame, 1);
`else
        chk("to_pulse", err_frame, 0);
`endif
        @(posedge clk); #1;
        chk("to_after", err_frame, 0);
        // reset mid-packet, asserted together with a strobe
        send_hdr();
        send(8'h02);
        rst = 1'b1;
        rx_if.rx_dv = 1'b1;
        rx_if.rx_byte = 8'h10;
        @(posedge clk); #1;
        rx_if.rx_dv = 1'b0;
        chk("mid_rst_pulses", {pkt_dv, err_len, err_frame}, 3'b000);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_cnt", pkt_cnt, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        snap();
        send_hdr();
        send_payload(8'h01);
        send_end("post_rst_eop", 3'b100);
        chk("post_rst_cnt", pkt_cnt, 1);
        chk("post_rst_pkts", n_pkt - p0, 1);
        chk("no_overlap", n_multi, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tsip_rx_framer.md
TSIP_RX_FRAMER -- requirements
Module: tsip_rx_framer

Interface
REQ-001 SHALL have parameter P_ID, default 8'h8F, TSIP packet ID to accept.
REQ-002 SHALL have parameter P_SUBCODE, default 8'hAB, subcode to accept; 0x00 means any subcode.
REQ-003 SHALL have parameter P_LEN, default 17, exact destuffed payload byte count (subcode through last data byte).
REQ-004 SHALL have parameter P_TIMEOUT_CLKS, default 20840, inter-byte timeout in clocks (two byte times at 9600 baud, 10 MHz).
REQ-005 SHALL have ports: i_clk in 1 clock; i_rst in 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: i_en in 1 enables framing (low while configuration packets are sent); i_rx_dv in 1 byte strobe from uart_rx; i_rx_byte in 8 received byte.
REQ-007 SHALL have ports: o_pkt_dv out 1 one-cycle good-packet pulse; o_data out 8*P_LEN payload, byte k at bits [8k+7:8k], subcode at byte 0.
REQ-008 SHALL have ports: o_err_len out 1 pulse; o_err_frame out 1 pulse; o_pkt_cnt out 16 good-packet count.

Function
REQ-009 SHALL implement states IDLE, HDR_DLE, HDR_ID, DATA, DATA_DLE, SKIP, SKIP_DLE; transitions only on cycles with i_rx_dv=1 (except REQ-017/REQ-018).
REQ-010 IDLE: DLE -> HDR_DLE; other bytes ignored.
REQ-011 HDR_DLE: byte == P_ID -> HDR_ID; byte DLE or ETX -> IDLE; any other byte -> SKIP.
REQ-012 HDR_ID: byte matches P_SUBCODE (or P_SUBCODE==0) -> store byte 0, count=1, DATA; otherwise SKIP.
REQ-013 DATA: DLE -> DATA_DLE; other byte -> store at index count, count+1.
REQ-014 DATA_DLE: DLE -> store single 0x10, DATA (destuffing); ETX -> end of packet, IDLE; other byte -> o_err_frame pulse, byte treated as new ID (== P_ID -> HDR_ID, else SKIP).
REQ-015 SHALL reach the end of packet with count == P_LEN -> o_pkt_dv=1, o_data loaded, o_pkt_cnt+1 (wraps 0xFFFF->0), all in the cycle after the ETX strobe; o_data SHALL hold until the next good packet.
REQ-016 SHALL handle length errors: count < P_LEN at end -> o_err_len pulse, no o_pkt_dv, o_data unchanged. A store attempt at count == P_LEN -> o_err_len pulse the next cycle, then -> SKIP with no further stores.
REQ-017 SKIP/SKIP_DLE SHALL consume bytes with the same DLE rules until DLE-ETX -> IDLE, with no pulses.
REQ-018 i_en low SHALL force IDLE the next cycle, discard the partial packet, and emit no pulses; o_data and o_pkt_cnt are kept.
REQ-019 o_pkt_dv, o_err_len, o_err_frame SHALL each be high for exactly one cycle per event, never simultaneously.
REQ-020 Payload index/counter width SHALL be $clog2(P_LEN+1) bits; storage is a P_LEN x 8 register array.

Reset
REQ-021 i_rst SHALL force state IDLE, count 0, o_pkt_dv/o_err_len/o_err_frame 0, o_data 0, o_pkt_cnt 0; reset mid-packet discards it silently.
REQ-022 Reset SHALL take priority over i_en and i_rx_dv in the same cycle.

Configuration
REQ-023 Macro TSIP_RX_TIMEOUT_EN defined: a counter clears on each i_rx_dv and increments otherwise in any non-IDLE state; reaching P_TIMEOUT_CLKS -> IDLE next cycle with o_err_frame pulse.
REQ-024 Macro TSIP_RX_TIMEOUT_EN undefined: no timeout counter exists; the block waits indefinitely in any state.

Structure
REQ-025 Shared package tsip_pkg SHALL hold TSIP_DLE=8'h10, TSIP_ETX=8'h03, TSIP_ID_CMD=8'h8E, TSIP_ID_RPT=8'h8F, TSIP_SUB_TIMING=8'hAB and the state enum type.
REQ-026 SHALL be a single module with no sub-module; it connects downstream of the existing uart_rx byte interface.

Verification
REQ-027 Good packet: 10 8F AB + 16 bytes 0x01..0x10 (0x10 sent stuffed as 10 10) + 10 03 -> one o_pkt_dv, o_data byte0=AB, byte16=0x10, o_pkt_cnt=1.
REQ-028 Foreign packet: 10 8F AC ... 10 03 -> no pulses; the following good packet is accepted normally.
REQ-029 Short packet: 10 8F AB + 10 data bytes + 10 03 -> o_err_len once, o_data unchanged, o_pkt_cnt unchanged.
REQ-030 Framing error: 10 8F AB 05 10 8F AB + 16 bytes + 10 03 -> o_err_frame once, then o_pkt_dv once.
REQ-031 Abort: i_en dropped after 8 payload bytes, then raised, then a full good packet -> exactly one o_pkt_dv; separately, i_rst mid-packet -> all outputs 0.
REQ-032 With TSIP_RX_TIMEOUT_EN: stream stops after 10 8F AB 01 -> o_err_frame exactly P_TIMEOUT_CLKS cycles after the last strobe (+1); without the macro -> no pulse.
